// File: rtl/demux_1x2_buf_if.sv
// demux_1x2_buf_if: stream bundle for the buffered 1-to-2 demultiplexer.
// Carries one 8-bit input stream (in/sel/in_valid/in_ready) and two
// 8-bit destination streams (outN/outN_valid/outN_ready).
//
// Handshake rule for every stream in this bundle: a word moves on a rising
// clock edge exactly when valid and ready are both high in the cycle before
// that edge. The producer holds data and valid stable until that happens.
// Ready may depend on the consumer's state but never on valid.
//
// master : the environment (drives the input stream, consumes the outputs)
// slave  : the demultiplexer itself
interface demux_1x2_buf_if;
    logic [7:0] in;
    logic       sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1;
    logic       out1_valid;
    logic       out1_ready;

    modport master (
        output in,
        output sel,
        output in_valid,
        input  in_ready,
        input  out0,
        input  out0_valid,
        output out0_ready,
        input  out1,
        input  out1_valid,
        output out1_ready
    );

    modport slave (
        input  in,
        input  sel,
        input  in_valid,
        output in_ready,
        output out0,
        output out0_valid,
        input  out0_ready,
        output out1,
        output out1_valid,
        input  out1_ready
    );
endinterface

// File: rtl/demux_1x2_buf.sv
// demux_1x2_buf: buffered 1-to-2 demultiplexer for the 8-bit datapath.
// Each input word is steered by its sel bit into one of two one-entry
// holding registers. Each destination has its own EMPTY/FULL FSM, so a
// stalled destination only blocks words addressed to it.
//
// Optional feature: define DEMUX_COUNT_EN to add the cnt0/cnt1 ports,
// 8-bit wrapping counters of words delivered on each destination.
//
// dbg_full exposes the FSM states: bit n is 1 when destination n is FULL.
module demux_1x2_buf (
    input  logic             clk,
    input  logic             rst,
    demux_1x2_buf_if.slave   bus,
`ifdef DEMUX_COUNT_EN
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
`endif
    output logic [1:0]       dbg_full
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t state0;
    slot_state_t state1;
    logic [7:0]  data0;
    logic [7:0]  data1;

    logic sel_ready;
    logic accept;
    logic accept0;
    logic accept1;
    logic deliver0;
    logic deliver1;

    // The selected slot can take a word if it is empty or is being drained
    // this very cycle; in_valid deliberately plays no part here.
    always_comb begin
        sel_ready = 1'b0;
        if (bus.sel) begin
            sel_ready = (state1 == EMPTY) || bus.out1_ready;
        end else begin
            sel_ready = (state0 == EMPTY) || bus.out0_ready;
        end
    end

    assign bus.in_ready = !rst && sel_ready;

    assign accept   = bus.in_valid && bus.in_ready;
    assign accept0  = accept && !bus.sel;
    assign accept1  = accept &&  bus.sel;
    assign deliver0 = (state0 == FULL) && bus.out0_ready;
    assign deliver1 = (state1 == FULL) && bus.out1_ready;

    // Destination 0 slot: load on accept, drop to EMPTY on a delivery that
    // is not refilled in the same cycle. The register keeps stale data
    // while EMPTY; consumers must ignore it then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state0 <= EMPTY;
            data0  <= 8'h00;
        end else begin
            case (state0)
                EMPTY: begin
                    if (accept0) begin
                        state0 <= FULL;
                        data0  <= bus.in;
                    end
                end
                FULL: begin
                    // accept0 while FULL implies out0_ready, i.e. the old
                    // word leaves on the same edge the new one arrives.
                    if (accept0) begin
                        data0 <= bus.in;
                    end else if (deliver0) begin
                        state0 <= EMPTY;
                    end
                end
                default: begin
                    state0 <= EMPTY;
                end
            endcase
        end
    end

    // Destination 1 slot: same behaviour as destination 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state1 <= EMPTY;
            data1  <= 8'h00;
        end else begin
            case (state1)
                EMPTY: begin
                    if (accept1) begin
                        state1 <= FULL;
                        data1  <= bus.in;
                    end
                end
                FULL: begin
                    if (accept1) begin
                        data1 <= bus.in;
                    end else if (deliver1) begin
                        state1 <= EMPTY;
                    end
                end
                default: begin
                    state1 <= EMPTY;
                end
            endcase
        end
    end

    assign bus.out0       = data0;
    assign bus.out1       = data1;
    assign bus.out0_valid = (state0 == FULL);
    assign bus.out1_valid = (state1 == FULL);
    assign dbg_full       = {state1 == FULL, state0 == FULL};

`ifdef DEMUX_COUNT_EN
    // Delivered-word counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 8'h00;
            cnt1 <= 8'h00;
        end else begin
            if (deliver0) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (deliver1) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule
